// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// legal byte-enable patterns, write-log format and the byte-enable legality helper.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  localparam string DM_LOG_FMT = "@%h: *%h <= %h";

  // Halfword and word accesses must be naturally aligned on the raw byte address.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] a_lo);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3: be_legal = 1'b1;
      BE_H0, BE_H1:               be_legal = ~a_lo[0];
      BE_W:                       be_legal = (a_lo == 2'b00);
      default:                    be_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Word-organised storage: byte-enable synchronous write, combinational read,
// asynchronous active-low clear of every word.
module dm_word_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int l = 0; l < 4; l++) begin
        if (be_i[l]) mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES busy cycles, registered response.
// Optional store logging is compiled in with the DM_WRITE_LOG_EN macro.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output dm_state_e   dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the requester holds req_* stable until accepted, and response outputs hold until resp_ready.
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  dm_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        lat_we_q, lat_we_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [3:0]  lat_be_q, lat_be_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [31:0] lat_pc_q, lat_pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        commit;

  // With zero wait states the commit edge is the accept edge, so checks look at the live request.
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata, off, ram_rdata;
  logic [3:0]  cur_be;
  logic        legal, ram_we;

  assign cur_we    = (state_q == IDLE) ? req_we    : lat_we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : lat_addr_q;
  assign cur_be    = (state_q == IDLE) ? req_be    : lat_be_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : lat_wdata_q;

  assign off    = cur_addr - BASE_ADDR;
  assign legal  = be_legal(cur_be, cur_addr[1:0]) && ((off >> (ADDR_WIDTH + 2)) == 32'd0);
  assign ram_we = commit && cur_we && legal;

  dm_word_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (ram_we),
    .be_i    (cur_be),
    .addr_i  (off[ADDR_WIDTH+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_be_d    = lat_be_q;
    lat_wdata_d = lat_wdata_q;
    lat_pc_d    = lat_pc_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lat_we_d    = req_we;
          lat_addr_d  = req_addr;
          lat_be_d    = req_be;
          lat_wdata_d = req_wdata;
          lat_pc_d    = req_pc;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = ~legal;
      rdata_d = (legal && !cur_we) ? ram_rdata : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_be_q    <= '0;
      lat_wdata_q <= '0;
      lat_pc_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_be_q    <= lat_be_d;
      lat_wdata_q <= lat_wdata_d;
      lat_pc_q    <= lat_pc_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign dbg_state_o = state_q;

`ifdef DM_WRITE_LOG_EN
  logic [31:0] be_mask, merged, cur_pc;
  assign cur_pc = (state_q == IDLE) ? req_pc : lat_pc_q;
  assign be_mask = {{8{cur_be[3]}}, {8{cur_be[2]}}, {8{cur_be[1]}}, {8{cur_be[0]}}};
  assign merged  = (ram_rdata & ~be_mask) | (cur_wdata & be_mask);

  always_ff @(posedge clk) begin
    if (reset && ram_we) $display(DM_LOG_FMT, cur_pc, {cur_addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^lat_pc_q;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one WAIT_CYCLES=2 instance and one WAIT_CYCLES=0 instance.
module tb_dm_responder;
  import dm_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // WAIT_CYCLES=2 instance
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, req_pc, resp_rdata;
  logic [3:0]  req_be;
  dm_state_e   dbg_state;

  // WAIT_CYCLES=0 instance
  logic        z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_req_pc, z_resp_rdata;
  logic [3:0]  z_req_be;
  dm_state_e   z_dbg_state;

  int total = 0;
  int bad   = 0;

  dm_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dbg_state_o(dbg_state)
  );

  dm_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_be(z_req_be), .req_wdata(z_req_wdata), .req_pc(z_req_pc),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
    .resp_err(z_resp_err), .dbg_state_o(z_dbg_state)
  );

  // Driver: called at a negedge, issues one request, returns response fields and
  // the number of rising edges from acceptance until resp_valid is seen. Ends at a negedge
  // after the response handshake.
  task automatic drv(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    int guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    req_pc = 32'h0000_1000; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = resp_rdata; er = resp_err;
    if (!resp_valid) begin
      bad++; $display("FAIL drv_timeout: no resp_valid for addr %h within %0d cycles", addr, lat);
    end
    total++;
    @(negedge clk);
  endtask

  task automatic drv_z(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] pc, output logic [31:0] rd,
                       output logic er, output int lat);
    int guard = 0;
    while (!z_req_ready && guard < 50) begin @(negedge clk); guard++; end
    z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_be = be; z_req_wdata = wd;
    z_req_pc = pc; z_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    z_req_valid = 1'b0;
    lat = 1;
    while (!z_resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = z_resp_rdata; er = z_resp_err;
    if (!z_resp_valid) begin
      bad++; $display("FAIL drvz_timeout: no resp_valid for addr %h within %0d cycles", addr, lat);
    end
    total++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", resp_err); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    reset = 1'b1;
    @(negedge clk);
    drv(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_mem: got %h want 0", rd); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    drv(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL st_latency: got %0d want 3", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL st_err: got %b want 0", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL st_rdata: got %h want 0", rd); end
    drv(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata: got %h want deadbeef", rd); end
    total++; if (lat !== 3) begin bad++; $display("FAIL ld_latency: got %0d want 3", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL ld_err: got %b want 0", er); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd; logic er; int lat;
    drv(1'b1, 32'h10, 4'hF, 32'h11223344, rd, er, lat);
    drv(1'b1, 32'h12, 4'b0100, 32'h00AB0000, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL lane_err: got %b want 0", er); end
    drv(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h11AB3344) begin bad++; $display("FAIL lane_merge: got %h want 11ab3344", rd); end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addrs [4] = '{32'h13, 32'h11, 32'h10, 32'h4000};
    logic [3:0]  bes   [4] = '{4'b1111, 4'b0011, 4'b0101, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, addrs[i], bes[i], 32'hFFFF_FFFF, rd, er, lat);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL ill_err[%0d]: got %b want 1", i, er); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL ill_rdata[%0d]: got %h want 0", i, rd); end
    end
    drv(1'b0, 32'h10, 4'b0101, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL ill_load: got err=%b rd=%h want err=1 rd=0", er, rd); end
    drv(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h11AB3344) begin bad++; $display("FAIL ill_unchanged: got %h want 11ab3344", rd); end
    drv(1'b0, 32'h0, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL ill_alias: got %h want 0", rd); end
    // Legal upper halfword and the last word of the array.
    drv(1'b1, 32'h12, 4'b1100, 32'h55660000, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL h1_err: got %b want 0", er); end
    drv(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h55663344) begin bad++; $display("FAIL h1_merge: got %h want 55663344", rd); end
    drv(1'b1, 32'h3FFC, 4'hF, 32'hCAFE0001, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL top_err: got %b want 0", er); end
    drv(1'b0, 32'h3FFC, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hCAFE0001) begin bad++; $display("FAIL top_rdata: got %h want cafe0001", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h0;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat !== 3) begin bad++; $display("FAIL bp_latency: got %0d want 3", lat); end
    // Offer a store while the response is stalled; it must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", c, resp_valid); end
      total++; if (resp_rdata !== 32'h55663344) begin bad++; $display("FAIL bp_rdata[%0d]: got %h want 55663344", c, resp_rdata); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d]: got %b want 0", c, req_ready); end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", resp_valid); end
    drv(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h55663344) begin bad++; $display("FAIL bp_ignored: got %h want 55663344", rd); end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd; logic er; int lat;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h12345678;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (dbg_state !== BUSY) begin bad++; $display("FAIL rb_busy: got %0d want 1", dbg_state); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rb_req_ready: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rb_resp_valid: got %b want 0", resp_valid); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drv(1'b0, 32'h20, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rb_no_write: got %h want 0", rd); end
    drv(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rb_cleared: got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    drv_z(1'b1, 32'h8, 4'hF, 32'h5, 32'h3000, rd, er, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL z_st_latency: got %0d want 1", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL z_st_err: got %b want 0", er); end
    total++; if (z_req_ready !== 1'b1) begin bad++; $display("FAIL z_ready_after: got %b want 1", z_req_ready); end
    drv_z(1'b1, 32'hC, 4'b0011, 32'h0000A0B0, 32'h3004, rd, er, lat);
    drv_z(1'b0, 32'h8, 4'hF, 32'h0, 32'h3008, rd, er, lat);
    total++; if (rd !== 32'h5 || lat !== 1) begin bad++; $display("FAIL z_ld0: got rd=%h lat=%0d want rd=5 lat=1", rd, lat); end
    drv_z(1'b0, 32'hC, 4'hF, 32'h0, 32'h300C, rd, er, lat);
    total++; if (rd !== 32'h0000A0B0 || lat !== 1) begin bad++; $display("FAIL z_ld1: got rd=%h lat=%0d want rd=a0b0 lat=1", rd, lat); end
    drv_z(1'b0, 32'hE, 4'hF, 32'h0, 32'h3010, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL z_ill: got err=%b rd=%h want err=1 rd=0", er, rd); end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; req_pc = '0;
    resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_be = '0; z_req_wdata = '0;
    z_req_pc = '0; z_resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_store_load();
    test_byte_lane();
    test_illegal();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the CPU data-memory port: accepts one load/store request at a time over a valid/ready handshake, inserts configurable wait states, then returns a response.
- Owns the word-organised data storage with byte-enable writes.
- Sits behind the MEM stage as the slave end of the data-memory interface; the MEM stage holds its request until it is accepted and stalls until the response arrives.

Parameters:
- ADDR_WIDTH, 12, word-index width; depth = 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 2, number of BUSY cycles between acceptance and response (0 legal).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present; requester holds all req_* stable until accepted.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_be  input  4  byte enables; bit i selects byte lane i = bits [8i+7:8i].
- req_wdata  input  32  store data, lane-aligned.
- req_pc  input  32  PC of the issuing instruction, used for logging only.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  full loaded word, unmasked; the CPU extracts bytes. Value is 0 for stores and errors.
- resp_err  output  1  request was rejected.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; wait counter 0; every storage word 0.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/be/wdata/pc. Go to BUSY with counter=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
  - BUSY: req_ready=0. Counter decrements each cycle; when the counter is 0, go to RESP.
  - RESP: resp_valid=1, req_ready=0. Outputs are held stable until resp_ready=1, then return to IDLE.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
- After a response handshake, req_ready=1 in the next cycle. Peak throughput is one access per WAIT_CYCLES+2 cycles.
- Commit point: read data is sampled and the store is written on the edge that enters RESP.
- Store write: only lanes with be[i]=1 are updated; other lanes keep their old value.
- Legality checks, all evaluated on the latched request:
  - Legal req_be patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - 0011/1100 require addr[0]=0.
  - 1111 requires addr[1:0]=0.
  - addr-BASE_ADDR (32-bit unsigned) must be < 4*2^ADDR_WIDTH.
  - Any violation: resp_err=1, no write, resp_rdata=0.
- Word index = (addr-BASE_ADDR)[ADDR_WIDTH+1:2].
- req_valid while req_ready=0 is ignored; no queuing.
- resp_ready while resp_valid=0 is ignored.
- Reset mid-operation: a request in BUSY is discarded with no write. Reset clears storage regardless of state.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- Defined: on every committed, non-error store, print via $display "@%h: *%h <= %h" with latched pc, word-aligned byte address, and the merged 32-bit word after the write.
- Not defined: no display statements are compiled; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - State encoding IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Byte-enable legal-pattern constants BE_B0..BE_B3, BE_H0, BE_H1, BE_W.
  - DM_LOG_FMT format string.
- One sub-module, dm_word_ram: synchronous byte-enable write, combinational read, async active-low clear, parameterised by ADDR_WIDTH. The handshake FSM, wait counter and legality checks stay in dm_responder.

Test Plan:
- WAIT_CYCLES=2, store addr 0x10, be=1111, wdata 0xDEADBEEF, resp_ready=1. Required: resp_valid exactly 3 cycles after acceptance, resp_err=0, resp_rdata=0. A following load of 0x10 returns 0xDEADBEEF.
- Store be=0100, addr 0x12, wdata 0x00AB0000 over word 0x11223344 at 0x10. Required: load returns 0x11AB3344.
- Illegal requests each return resp_err=1 with memory unchanged:
  - be=1111 at 0x13.
  - be=0011 at 0x11.
  - be=0101.
  - Address 0x4000 with ADDR_WIDTH=12.
- Backpressure: hold resp_ready=0 for 5 cycles. Required: resp_valid and resp_rdata stable throughout, req_ready=0, and a new req_valid is ignored. After resp_ready=1, req_ready=1 in the next cycle.
- Reset pulsed low during BUSY of store 0x20 = 0x12345678. Required: req_ready=1 and resp_valid=0 immediately; a later load of 0x20 returns 0.
- WAIT_CYCLES=0 with back-to-back loads. Required: resp_valid 1 cycle after each acceptance. With DM_WRITE_LOG_EN defined, store pc 0x3000 to addr 0x8 data 0x5 prints "@00003000: *00000008 <= 00000005".
